// File: rtl/bldc_hall_sample_scheduler.sv
// Periodic sweep of NUM_MOTORS hall counters into signed per-period deltas, with clear
// sequencing on the shared counter reset line and a 1-cycle-latency host read port.
module bldc_hall_sample_scheduler #(
   parameter int unsigned NUM_MOTORS    = 5,
   parameter int unsigned COUNTER_WIDTH = 8,
   parameter int unsigned PERIOD_CYCLES = 18432,
   parameter int unsigned ADDR_WIDTH    = 3
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_MOTORS*COUNTER_WIDTH-1:0] counts,
   output logic                                counter_reset,
   input  logic                                clr_req,
   input  logic [ADDR_WIDTH-1:0]               rd_addr,
   input  logic                                rd_en,
   output logic [COUNTER_WIDTH-1:0]            rd_data,
   output logic                                sample_valid,
   output logic [7:0]                          sample_seq,
   output logic                                busy
);

   localparam int unsigned TimerWidth = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int unsigned IdxWidth   = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
   localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(PERIOD_CYCLES - 1);
   localparam logic [IdxWidth-1:0]   IdxLast   = IdxWidth'(NUM_MOTORS - 1);

   typedef enum logic [1:0] {StIdle, StSweep, StClear, StDone} state_e;

   state_e                   state_q, state_d;
   logic [TimerWidth-1:0]    timer_q, timer_d;
   logic                     tick;
   logic                     tick_pending_q, tick_pending_d;
   logic                     clr_pending_q, clr_pending_d;
   logic                     enter_sweep, enter_clear;
   logic [IdxWidth-1:0]      idx_q, idx_d;
   logic [COUNTER_WIDTH-1:0] prev_q  [NUM_MOTORS];
   logic [COUNTER_WIDTH-1:0] prev_d  [NUM_MOTORS];
   logic [COUNTER_WIDTH-1:0] delta_q [NUM_MOTORS];
   logic [COUNTER_WIDTH-1:0] delta_d [NUM_MOTORS];
   logic [7:0]               seq_q, seq_d;
   logic [COUNTER_WIDTH-1:0] rd_data_q, rd_data_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // IDLE, CLEAR and DONE dispatch identically, so deferred work starts on the very next cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StClear, StDone: begin
            if (clr_pending_q) begin
               state_d = StClear;
            end else if (tick_pending_q) begin
               state_d = StSweep;
            end else begin
               state_d = StIdle;
            end
         end
         StSweep: state_d = (idx_q == IdxLast) ? StDone : StSweep;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      counter_reset = (state_q == StClear);
      busy          = (state_q == StSweep) || (state_q == StClear);
      sample_valid  = (state_q == StDone);
   end

   always_comb begin
      tick           = (timer_q == TimerLast);
      timer_d        = tick ? '0 : timer_q + 1'b1;
      enter_sweep    = (state_d == StSweep) && (state_q != StSweep);
      enter_clear    = (state_d == StClear);
      // A request landing on the entry cycle survives and is serviced next.
      tick_pending_d = tick | (tick_pending_q & ~enter_sweep);
      clr_pending_d  = clr_req | (clr_pending_q & ~enter_clear);
      idx_d          = enter_sweep ? '0 : ((state_q == StSweep) ? idx_q + 1'b1 : idx_q);
      seq_d          = (state_q == StDone) ? seq_q + 8'd1 : seq_q;

      prev_d  = prev_q;
      delta_d = delta_q;
      for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
         if (state_q == StClear) begin
            prev_d[i] = '0;
         end else if ((state_q == StSweep) && (idx_q == IdxWidth'(i))) begin
            delta_d[i] = counts[i*COUNTER_WIDTH +: COUNTER_WIDTH] - prev_q[i];
            prev_d[i]  = counts[i*COUNTER_WIDTH +: COUNTER_WIDTH];
         end
      end

      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = '0;
         for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
               rd_data_d = delta_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q        <= '0;
         tick_pending_q <= 1'b0;
         clr_pending_q  <= 1'b0;
         idx_q          <= '0;
         prev_q         <= '{default: '0};
         delta_q        <= '{default: '0};
         seq_q          <= '0;
         rd_data_q      <= '0;
      end else begin
         timer_q        <= timer_d;
         tick_pending_q <= tick_pending_d;
         clr_pending_q  <= clr_pending_d;
         idx_q          <= idx_d;
         prev_q         <= prev_d;
         delta_q        <= delta_d;
         seq_q          <= seq_d;
         rd_data_q      <= rd_data_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign sample_seq = seq_q;

endmodule

// File: tb/tb_bldc_hall_sample_scheduler.sv
// Bench for bldc_hall_sample_scheduler: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the sweep/clear schedule and delta arithmetic.
module tb_bldc_hall_sample_scheduler;

   localparam int N  = 5;
   localparam int W  = 8;
   localparam int P  = 16;
   localparam int AW = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N*W-1:0] counts;
   logic           counter_reset;
   logic           clr_req;
   logic [AW-1:0]  rd_addr;
   logic           rd_en;
   logic [W-1:0]   rd_data;
   logic           sample_valid;
   logic [7:0]     sample_seq;
   logic           busy;

   always #5 clk = ~clk;

   bldc_hall_sample_scheduler #(
      .NUM_MOTORS   (N),
      .COUNTER_WIDTH(W),
      .PERIOD_CYCLES(P),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .counts       (counts),
      .counter_reset(counter_reset),
      .clr_req      (clr_req),
      .rd_addr      (rd_addr),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .sample_valid (sample_valid),
      .sample_seq   (sample_seq),
      .busy         (busy)
   );

   // Hall counter bank driven by the bench; zeroed after the DUT pulses counter_reset.
   logic [W-1:0] hall [N];
   always_comb begin
      for (int i = 0; i < N; i++) counts[i*W +: W] = hall[i];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit rand_counts = 1'b0;
   bit cr_last     = 1'b0;

   // Model: m_pos is -1 when not sampling, 0..N-1 for the channel being sampled, N for the
   // completion cycle; m_clr marks the single clear cycle.
   int           m_timer;
   bit           m_tick_p, m_clr_p, m_clr;
   int           m_pos;
   logic [7:0]   m_seq;
   logic [W-1:0] m_prev  [N];
   logic [W-1:0] m_delta [N];
   logic [W-1:0] m_rd;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit tk, go_clear, go_sweep;
      if (reset) begin
         m_timer = 0; m_tick_p = 0; m_clr_p = 0; m_clr = 0; m_pos = -1; m_seq = 0; m_rd = 0;
         for (int i = 0; i < N; i++) begin m_prev[i] = 0; m_delta[i] = 0; end
         return;
      end
      tk = (m_timer == P - 1);
      if (rd_en) m_rd = (int'(rd_addr) < N) ? m_delta[int'(rd_addr)] : '0;
      if (m_clr) begin
         for (int i = 0; i < N; i++) m_prev[i] = 0;
      end else if (m_pos >= 0 && m_pos < N) begin
         m_delta[m_pos] = hall[m_pos] - m_prev[m_pos];
         m_prev[m_pos]  = hall[m_pos];
      end
      go_clear = 0;
      go_sweep = 0;
      if (m_pos == N) m_seq = m_seq + 8'd1;
      if (m_pos < 0 || m_pos == N) begin
         if (m_clr_p) go_clear = 1;
         else if (m_tick_p) go_sweep = 1;
         m_clr = go_clear;
         m_pos = go_sweep ? 0 : -1;
      end else begin
         m_clr = 0;
         m_pos = m_pos + 1;
      end
      m_clr_p  = (go_clear ? 1'b0 : m_clr_p) | clr_req;
      m_tick_p = (go_sweep ? 1'b0 : m_tick_p) | tk;
      m_timer  = tk ? 0 : m_timer + 1;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      check_eq("counter_reset", {31'd0, counter_reset}, {31'd0, m_clr});
      check_eq("busy", {31'd0, busy}, {31'd0, (m_clr || (m_pos >= 0 && m_pos < N))});
      check_eq("sample_valid", {31'd0, sample_valid}, {31'd0, (m_pos == N)});
      check_eq("sample_seq", {24'd0, sample_seq}, {24'd0, m_seq});
      check_eq("rd_data", {24'd0, rd_data}, {24'd0, m_rd});
      if (cr_last) begin
         for (int i = 0; i < N; i++) hall[i] = '0;
      end else if (rand_counts) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0) hall[i] = $urandom_range(1) ? hall[i] + 8'd1 : hall[i] - 8'd1;
         end
      end
      cr_last = counter_reset;
   endtask

   task automatic wait_valid(output int at);
      int k;
      cycle();
      k = 1;
      while (sample_valid !== 1'b1 && k < 64) begin cycle(); k++; end
      check_eq("wait_valid_in_budget", {31'd0, sample_valid === 1'b1}, 32'd1);
      at = cyc;
   endtask

   task automatic wait_pos(input int p);
      int k = 0;
      while (m_pos != p && k < 64) begin cycle(); k++; end
      check_eq("wait_pos_in_budget", {31'd0, m_pos == p}, 32'd1);
   endtask

   task automatic read_chk(input int a, input logic [W-1:0] exp, input string tag);
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      cycle();
      rd_en   = 1'b0;
      check_eq(tag, {24'd0, rd_data}, {24'd0, exp});
   endtask

   initial begin
      int v1, v2, k, cr_cnt, v_cnt, cr_at, sw_at;
      reset = 1'b1; clr_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
      for (int i = 0; i < N; i++) hall[i] = 8'd3;
      repeat (3) cycle();
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_seq", {24'd0, sample_seq}, 32'd0);
      check_eq("rst_rd_data", {24'd0, rd_data}, 32'd0);
      reset = 1'b0;

      // Constant counts: first sweep sees +3, the next sees 0, one pulse per period.
      wait_valid(v1);
      for (int i = 0; i < N; i++) read_chk(i, 8'd3, $sformatf("basic_delta3_ch%0d", i));
      check_eq("basic_seq1", {24'd0, sample_seq}, 32'd1);
      wait_valid(v2);
      check_eq("basic_period", v2 - v1, P);
      for (int i = 0; i < N; i++) read_chk(i, 8'd0, $sformatf("basic_delta0_ch%0d", i));
      check_eq("basic_seq2", {24'd0, sample_seq}, 32'd2);

      // Counter wrap in both directions.
      hall[0] = 8'd250; hall[1] = 8'd4;
      wait_valid(v1);
      hall[0] = 8'd4; hall[1] = 8'd250;
      wait_valid(v1);
      read_chk(0, 8'h0A, "wrap_plus10");
      read_chk(1, 8'hF6, "wrap_minus10");

      // Sample point: channel 2 change during idx=1 is caught, after idx=2 is deferred.
      hall[2] = 8'd5;
      wait_valid(v1);
      wait_pos(1);
      hall[2] = 8'd9;
      wait_pos(3);
      hall[2] = 8'd20;
      wait_valid(v1);
      read_chk(2, 8'd4, "timing_same_sweep");
      wait_valid(v1);
      read_chk(2, 8'd11, "timing_next_sweep");

      // Clear requested mid-sweep runs right after DONE; next deltas equal raw counts.
      wait_pos(1);
      clr_req = 1'b1; cycle(); clr_req = 1'b0;
      wait_valid(v1);
      cycle();
      check_eq("clr_after_done", {31'd0, counter_reset}, 32'd1);
      cycle();
      check_eq("clr_one_cycle", {31'd0, counter_reset}, 32'd0);
      for (int i = 0; i < N; i++) hall[i] = W'(i * 7 + 1);
      wait_valid(v1);
      for (int i = 0; i < N; i++) read_chk(i, W'(i * 7 + 1), $sformatf("clr_raw_ch%0d", i));

      // Clear and tick together: clear first, sweep immediately after, one sample pulse.
      k = 0;
      while (!(m_timer == P - 1 && m_pos == -1 && !m_clr) && k < 64) begin cycle(); k++; end
      check_eq("tick_align_in_budget", {31'd0, k < 64}, 32'd1);
      clr_req = 1'b1; cycle(); clr_req = 1'b0;
      cr_cnt = 0; v_cnt = 0; cr_at = -1; sw_at = -1;
      for (int j = 0; j < 12; j++) begin
         cycle();
         if (counter_reset === 1'b1) begin cr_cnt++; if (cr_at < 0) cr_at = j; end
         if (sample_valid === 1'b1) v_cnt++;
         if (busy === 1'b1 && counter_reset !== 1'b1 && sw_at < 0) sw_at = j;
      end
      check_eq("clrtick_clear_count", cr_cnt, 1);
      check_eq("clrtick_valid_count", v_cnt, 1);
      check_eq("clrtick_sweep_follows", sw_at, cr_at + 1);

      // Reset mid-sweep wipes everything.
      wait_pos(2);
      reset = 1'b1; cycle(); reset = 1'b0;
      check_eq("midrst_busy", {31'd0, busy}, 32'd0);
      check_eq("midrst_counter_reset", {31'd0, counter_reset}, 32'd0);
      check_eq("midrst_seq", {24'd0, sample_seq}, 32'd0);
      for (int i = 0; i < N; i++) read_chk(i, 8'd0, $sformatf("midrst_delta_ch%0d", i));
      read_chk(7, 8'd0, "midrst_addr7");

      // Random traffic against the model.
      rand_counts = 1'b1;
      for (int j = 0; j < 800; j++) begin
         clr_req = ($urandom_range(29) == 0);
         rd_en   = $urandom_range(1) == 1;
         rd_addr = AW'($urandom_range(7));
         reset   = ($urandom_range(499) == 0);
         cycle();
      end
      reset = 1'b0; clr_req = 1'b0; rd_en = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
